// File: rtl/serial_packet_demux.sv
// Framed serial packet demultiplexer: start bit, port address, payload length, payload.
// Routes payload bits to one of PORTS outputs and shows remaining payload count on two 7-seg digits.
module serial_packet_demux #(
    parameter int PORTS    = 4,
    parameter int LEN_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clkEN,
    input  logic             SerIn,
    output logic [PORTS-1:0] P,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [6:0]       SSD_OUT_LOW,
    output logic [6:0]       SSD_OUT_HIGH
);
    localparam int PW = $clog2(PORTS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PORT = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_reg, state_next;
    logic [PW-1:0]       addr_reg, addr_next;
    logic [LEN_BITS-1:0] len_reg, len_next;
    logic [LEN_BITS-1:0] rem_reg, rem_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic                busy_reg, busy_next;
    logic                err_reg, err_next;

    logic [PW-1:0]       addr_shift;
    logic [LEN_BITS-1:0] len_shift;
    logic                addr_ok;
    logic                data_active;

    assign addr_shift  = PW'({addr_reg, SerIn});
    assign len_shift   = LEN_BITS'({len_reg, SerIn});
    assign addr_ok     = {{(32-PW){1'b0}}, addr_reg} < 32'(PORTS);
    assign data_active = (state_reg == S_DATA) && addr_ok;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        case (state_reg)
            S_IDLE: begin
                if (clkEN && !SerIn) begin
                    err_next   = 1'b0;
                    cnt_next   = 3'd0;
                    state_next = S_PORT;
                end
            end
            S_PORT: begin
                if (clkEN) begin
                    addr_next = addr_shift;
                    if (cnt_reg == 3'(PW - 1)) begin
                        cnt_next   = 3'd0;
                        state_next = S_LEN;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            S_LEN: begin
                if (clkEN) begin
                    len_next = len_shift;
                    if (cnt_reg == 3'(LEN_BITS - 1)) begin
                        cnt_next = 3'd0;
                        rem_next = len_shift;
                        // A zero-length packet still closes with a DONE cycle so err/done behave uniformly.
                        if (len_shift == '0) begin
                            state_next = S_DONE;
                            err_next   = !addr_ok;
                        end else begin
                            state_next = S_DATA;
                        end
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
            end
            S_DATA: begin
                if (clkEN) begin
                    rem_next = rem_reg - LEN_BITS'(1);
                    if (rem_reg == LEN_BITS'(1)) begin
                        state_next = S_DONE;
                        err_next   = !addr_ok;
                    end
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        busy_next = (state_next == S_PORT) || (state_next == S_LEN) || (state_next == S_DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            len_reg   <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            err_reg   <= err_next;
        end
    end

    // Out-of-range addresses select no output bit, so their payload is dropped.
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
        assign P[gi] = data_active && (addr_reg == PW'(gi)) && SerIn;
    end

    assign busy = busy_reg;
    assign done = (state_reg == S_DONE);
    assign err  = err_reg;

    function automatic logic [6:0] seg7(input logic [6:0] d);
        case (d)
            7'd0:    seg7 = 7'b1000000;
            7'd1:    seg7 = 7'b1111001;
            7'd2:    seg7 = 7'b0100100;
            7'd3:    seg7 = 7'b0110000;
            7'd4:    seg7 = 7'b0011001;
            7'd5:    seg7 = 7'b0010010;
            7'd6:    seg7 = 7'b0000010;
            7'd7:    seg7 = 7'b1111000;
            7'd8:    seg7 = 7'b0000000;
            7'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1000000;
        endcase
    endfunction

    logic [6:0] rem_wide;
    assign rem_wide     = 7'(rem_reg);
    assign SSD_OUT_HIGH = seg7(rem_wide / 7'd10);
    assign SSD_OUT_LOW  = seg7(rem_wide % 7'd10);
endmodule

// File: tb/tb_serial_packet_demux.sv
// Directed bench for serial_packet_demux: a 4-port and a 3-port instance share the same serial stimulus.
module tb_serial_packet_demux;
    logic       clk = 1'b0;
    logic       reset, clkEN, SerIn;
    logic [3:0] p4;
    logic [2:0] p3;
    logic       busy4, done4, err4, busy3, done3, err3;
    logic [6:0] lo4, hi4, lo3, hi3;
    int         n_checks = 0;
    int         n_fail   = 0;

    localparam logic [6:0] SEGS [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    serial_packet_demux #(.PORTS(4), .LEN_BITS(5)) dut4 (
        .clk(clk), .reset(reset), .clkEN(clkEN), .SerIn(SerIn), .P(p4),
        .busy(busy4), .done(done4), .err(err4), .SSD_OUT_LOW(lo4), .SSD_OUT_HIGH(hi4));

    serial_packet_demux #(.PORTS(3), .LEN_BITS(5)) dut3 (
        .clk(clk), .reset(reset), .clkEN(clkEN), .SerIn(SerIn), .P(p3),
        .busy(busy3), .done(done3), .err(err3), .SSD_OUT_LOW(lo3), .SSD_OUT_HIGH(hi3));

    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic en);
        SerIn = s;
        clkEN = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1; SerIn = 1'b1; clkEN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({p4, busy4, done4, err4} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs4 got=%b want=%b", {p4, busy4, done4, err4}, 7'b0);
        end
        n_checks++;
        if ({p3, busy3, done3, err3} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs3 got=%b want=%b", {p3, busy3, done3, err3}, 6'b0);
        end
        n_checks++;
        if ({hi4, lo4, hi3, lo3} !== {SEGS[0], SEGS[0], SEGS[0], SEGS[0]}) begin
            n_fail++; $display("FAIL reset_display got=%b want=%b", {hi4, lo4, hi3, lo3}, {4{SEGS[0]}});
        end
        reset = 1'b0;
        drive(1'b1, 1'b1);
        $display("test_reset done");
    endtask

    task automatic test_basic_packet;
        logic [2:0] d = 3'b101;
        drive(1'b0, 1'b1);
        n_checks++;
        if (busy4 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_port got=%b want=1", busy4); end
        send_bits(32'b10_00011, 7);
        n_checks++;
        if ({hi4, lo4} !== {SEGS[0], SEGS[3]}) begin
            n_fail++; $display("FAIL basic_first_data_disp got=%b want=%b", {hi4, lo4}, {SEGS[0], SEGS[3]});
        end
        for (int k = 0; k < 3; k++) begin
            SerIn = d[2-k]; clkEN = 1'b1; #1;
            n_checks++;
            if (p4 !== (d[2-k] ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL basic_p4_tick%0d got=%b want=%b", k, p4, d[2-k] ? 4'b0100 : 4'b0000);
            end
            n_checks++;
            if (p3 !== (d[2-k] ? 3'b100 : 3'b000)) begin
                n_fail++; $display("FAIL basic_p3_tick%0d got=%b want=%b", k, p3, d[2-k] ? 3'b100 : 3'b000);
            end
            n_checks++;
            if ({busy4, hi4, lo4} !== {1'b1, SEGS[0], SEGS[3-k]}) begin
                n_fail++; $display("FAIL basic_busy_disp_tick%0d got=%b want=%b", k, {busy4, hi4, lo4}, {1'b1, SEGS[0], SEGS[3-k]});
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({done4, busy4, err4, hi4, lo4} !== {3'b100, SEGS[0], SEGS[0]}) begin
            n_fail++; $display("FAIL basic_done got=%b want=%b", {done4, busy4, err4, hi4, lo4}, {3'b100, SEGS[0], SEGS[0]});
        end
        drive(1'b1, 1'b1);
        n_checks++;
        if ({done4, busy4} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done got=%b want=00", {done4, busy4}); end
        $display("test_basic_packet done");
    endtask

    task automatic test_zero_length;
        send_bits(32'b0_00_00000, 8);
        n_checks++;
        if ({done4, busy4, err4, p4} !== 7'b1000000) begin
            n_fail++; $display("FAIL zero_len_done got=%b want=%b", {done4, busy4, err4, p4}, 7'b1000000);
        end
        drive(1'b1, 1'b1);
        n_checks++;
        if ({done4, p4} !== 5'b0) begin n_fail++; $display("FAIL zero_len_single_pulse got=%b want=00000", {done4, p4}); end
        $display("test_zero_length done");
    endtask

    task automatic test_invalid_addr;
        send_bits(32'b0_11_00010, 8);
        for (int k = 0; k < 2; k++) begin
            SerIn = 1'b1; clkEN = 1'b1; #1;
            n_checks++;
            if (p3 !== 3'b000) begin n_fail++; $display("FAIL invalid_p3_tick%0d got=%b want=000", k, p3); end
            n_checks++;
            if (p4 !== 4'b1000) begin n_fail++; $display("FAIL valid_p4_port3_tick%0d got=%b want=1000", k, p4); end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({done3, err3, err4} !== 3'b110) begin
            n_fail++; $display("FAIL invalid_err_in_done got=%b want=110", {done3, err3, err4});
        end
        drive(1'b1, 1'b1);
        n_checks++;
        if ({done3, err3} !== 2'b01) begin n_fail++; $display("FAIL invalid_err_sticky got=%b want=01", {done3, err3}); end
        drive(1'b0, 1'b1);
        n_checks++;
        if ({err3, busy3} !== 2'b01) begin n_fail++; $display("FAIL invalid_err_clear got=%b want=01", {err3, busy3}); end
        reset = 1'b1;
        drive(1'b1, 1'b1);
        reset = 1'b0;
        $display("test_invalid_addr done");
    endtask

    task automatic test_two_digit;
        send_bits(32'b0_00_10111, 8);
        n_checks++;
        if ({hi4, lo4} !== {SEGS[2], SEGS[3]}) begin
            n_fail++; $display("FAIL len23_first_disp got=%b want=%b", {hi4, lo4}, {SEGS[2], SEGS[3]});
        end
        for (int k = 1; k <= 23; k++) begin
            drive(k[0], 1'b1);
            if (k == 13) begin
                n_checks++;
                if ({hi4, lo4} !== {SEGS[1], SEGS[0]}) begin
                    n_fail++; $display("FAIL len23_disp10 got=%b want=%b", {hi4, lo4}, {SEGS[1], SEGS[0]});
                end
            end
            if (k == 22) begin
                n_checks++;
                if ({hi4, lo4} !== {SEGS[0], SEGS[1]}) begin
                    n_fail++; $display("FAIL len23_disp01 got=%b want=%b", {hi4, lo4}, {SEGS[0], SEGS[1]});
                end
            end
        end
        n_checks++;
        if ({done4, hi4, lo4} !== {1'b1, SEGS[0], SEGS[0]}) begin
            n_fail++; $display("FAIL len23_end got=%b want=%b", {done4, hi4, lo4}, {1'b1, SEGS[0], SEGS[0]});
        end
        drive(1'b1, 1'b1);
        $display("test_two_digit done");
    endtask

    task automatic test_clken_toggle;
        logic [7:0] hdr = 8'b0_10_00011;
        logic [2:0] d   = 3'b101;
        drive(1'b0, 1'b0);
        n_checks++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL toggle_idle_hold got=%b want=0", busy4); end
        for (int i = 7; i >= 0; i--) begin
            drive(hdr[i], 1'b1);
            drive(hdr[i], 1'b0);
        end
        n_checks++;
        if ({busy4, hi4, lo4} !== {1'b1, SEGS[0], SEGS[3]}) begin
            n_fail++; $display("FAIL toggle_header got=%b want=%b", {busy4, hi4, lo4}, {1'b1, SEGS[0], SEGS[3]});
        end
        for (int k = 0; k < 2; k++) begin
            SerIn = d[2-k]; clkEN = 1'b1; #1;
            n_checks++;
            if (p4 !== (d[2-k] ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL toggle_p4_en1_tick%0d got=%b want=%b", k, p4, d[2-k] ? 4'b0100 : 4'b0000);
            end
            @(posedge clk); #1;
            clkEN = 1'b0; #1;
            n_checks++;
            if (p4 !== (d[2-k] ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL toggle_p4_en0_tick%0d got=%b want=%b", k, p4, d[2-k] ? 4'b0100 : 4'b0000);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({hi4, lo4} !== {SEGS[0], SEGS[2-k]}) begin
                n_fail++; $display("FAIL toggle_frozen_disp%0d got=%b want=%b", k, {hi4, lo4}, {SEGS[0], SEGS[2-k]});
            end
        end
        SerIn = 1'b1; clkEN = 1'b1; #1;
        n_checks++;
        if (p4 !== 4'b0100) begin n_fail++; $display("FAIL toggle_p4_last got=%b want=0100", p4); end
        @(posedge clk); #1;
        n_checks++;
        if (done4 !== 1'b1) begin n_fail++; $display("FAIL toggle_done got=%b want=1", done4); end
        drive(1'b1, 1'b0);
        n_checks++;
        if ({done4, busy4} !== 2'b00) begin n_fail++; $display("FAIL toggle_done_one_clk got=%b want=00", {done4, busy4}); end
        $display("test_clken_toggle done");
    endtask

    task automatic test_reset_mid_data;
        send_bits(32'b0_01_00111, 8);
        send_bits(32'b11, 2);
        n_checks++;
        if ({hi4, lo4} !== {SEGS[0], SEGS[5]}) begin
            n_fail++; $display("FAIL midrst_rem5 got=%b want=%b", {hi4, lo4}, {SEGS[0], SEGS[5]});
        end
        reset = 1'b1;
        drive(1'b1, 1'b1);
        reset = 1'b0;
        n_checks++;
        if ({busy4, done4, p4, hi4, lo4} !== {6'b0, SEGS[0], SEGS[0]}) begin
            n_fail++; $display("FAIL midrst_cleared got=%b want=%b", {busy4, done4, p4, hi4, lo4}, {6'b0, SEGS[0], SEGS[0]});
        end
        drive(1'b1, 1'b1);
        n_checks++;
        if ({done4, busy4} !== 2'b00) begin n_fail++; $display("FAIL midrst_no_done got=%b want=00", {done4, busy4}); end
        send_bits(32'b0_01_00010, 8);
        for (int k = 0; k < 2; k++) begin
            SerIn = 1'b1; clkEN = 1'b1; #1;
            n_checks++;
            if (p4 !== 4'b0010) begin n_fail++; $display("FAIL midrst_next_p4_tick%0d got=%b want=0010", k, p4); end
            @(posedge clk); #1;
        end
        n_checks++;
        if ({done4, hi4, lo4} !== {1'b1, SEGS[0], SEGS[0]}) begin
            n_fail++; $display("FAIL midrst_next_done got=%b want=%b", {done4, hi4, lo4}, {1'b1, SEGS[0], SEGS[0]});
        end
        drive(1'b1, 1'b1);
        $display("test_reset_mid_data done");
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_zero_length();
        test_invalid_addr();
        test_two_digit();
        test_clken_toggle();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_packet_demux.md
Name: serial_packet_demux

Overview:
- Parametrised successor to the fixed 4-port, 5-bit-length serial demux datapath, with its controller integrated.
- Receives framed serial packets on SerIn: start bit, port address, payload length, payload bits.
- Routes the payload bits to one of PORTS outputs and shows the remaining payload count in decimal on two seven-segment digits.
- Adds behaviour the previous block lacks: start-bit framing, zero-length packets, an invalid-address error flag, and busy/done status.

Parameters:
- PORTS, 4, number of output ports (2..16); address field width PW = clog2(PORTS).
- LEN_BITS, 5, payload length field width (1..6); maximum payload is 2^LEN_BITS-1, so it always fits two decimal digits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- clkEN  input  1  bit-tick enable; serial sampling and counting advance only on clk edges where clkEN=1.
- SerIn  input  1  serial data in, MSB first for all fields; line idles high.
- P  output  PORTS  demultiplexed payload outputs.
- busy  output  1  high in PORT, LEN and DATA states.
- done  output  1  one-clk pulse at end of each packet.
- err  output  1  sticky: last packet addressed a port >= PORTS.
- SSD_OUT_LOW  output  7  units digit, bits {g,f,e,d,c,b,a}, active-low.
- SSD_OUT_HIGH  output  7  tens digit, same encoding.

Behaviour:
- Reset (synchronous, active-high, wins over everything, including mid-packet):
  - state=IDLE; all shift registers, bit counter and remaining counter = 0.
  - P=0, busy=0, done=0, err=0.
  - Both digits show "0" (7'b1000000).
- States: IDLE, PORT, LEN, DATA, DONE. All transitions except DONE->IDLE happen only on ticks (clkEN=1).
- IDLE: on a tick with SerIn=0, clear err and the bit counter, then go to PORT.
- PORT:
  - Shift SerIn into the address register, MSB first, for PW ticks.
  - After the PW-th tick, go to LEN.
- LEN:
  - Shift SerIn into the length register for LEN_BITS ticks.
  - After the last tick, load the remaining counter with the shifted value, including the bit sampled on that same tick.
  - If the value is 0, go to DONE; otherwise go to DATA.
- DATA:
  - Each tick decrements the remaining counter.
  - The tick on which remaining==1 is the last payload bit; go to DONE, with remaining ending at 0.
- DONE:
  - Lasts exactly one clk cycle regardless of clkEN; done=1, then go to IDLE.
  - err is set in DONE if address >= PORTS.
- P is combinational:
  - In DATA with address < PORTS: P[address]=SerIn, all other bits 0.
  - Otherwise P=0. An invalid address therefore silently drops the payload.
- busy is registered from state; done is high only in DONE.
- Display:
  - tens = remaining/10, units = remaining%10, computed combinationally from the remaining counter.
  - Codes, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - The display reads the loaded length on the first DATA cycle and 0 after the packet.
- Back-to-back packets: the first tick in IDLE after DONE may be the next start bit.
- A SerIn=1 tick in IDLE is ignored. clkEN=0 freezes all state except DONE->IDLE.

Test Plan:
- PORTS=4, LEN_BITS=5, clkEN=1 throughout: SerIn 0, addr 1,0, len 0,0,0,1,1, data 1,0,1 -> P=0100,0000,0100 during the data ticks; display 03/02/01 on those ticks; busy high; done pulses once; display then 00.
- Zero length (addr 00, len 00000) -> goes straight to DONE; done pulses once; P stays 0; err=0.
- PORTS=3, LEN_BITS=5, addr 11, len 00010, data 1,1 -> P stays 000 throughout; err=1 from DONE onward; err clears at the next start bit.
- Length 10111 -> SSD_OUT_HIGH=0100100 ("2") and SSD_OUT_LOW=0110000 ("3") on the first DATA cycle; both digits are "0" after the 23rd tick.
- clkEN toggling 1,0,1,0 through a packet -> state advances only on clkEN=1 edges; DONE lasts one clk even with clkEN=0; P output matches the clkEN=1 run tick for tick.
- Reset asserted for one cycle mid-DATA (remaining=5) -> next cycle IDLE, P=0, busy=0, display 00, no done pulse; a subsequent full packet is received correctly.
